// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit:
// FSM states, opcodes, ALU codes, datapath mux selects and the control bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, LUI, FAULT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SLL   = 3'b101;
  localparam logic [2:0] ALU_XOR   = 3'b110;
  localparam logic [2:0] ALU_SRL   = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // What the FSM asks of the ALU; the decoder turns it into a code.
  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_PASSB, AOP_FUNC} alu_op_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    alu_op_t    alu_op;
    logic       illegal;
    logic       fault;
  } ctrl_t;

endpackage

// File: rtl/mc_control_unit_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU request plus func3/func7_5
// to the 3-bit ALU code, zero-extended to ALU_CTRL_W.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  alu_op_t               op_i,
  input  logic [2:0]            func3_i,
  input  logic                  opcode5_i,
  input  logic                  func7_5_i,
  output logic [ALU_CTRL_W-1:0] alu_control_o
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    case (op_i)
      AOP_SUB:   code = ALU_SUB;
      AOP_PASSB: code = ALU_PASSB;
      AOP_FUNC: begin
        case (func3_i)
          // addi never subtracts: func7_5 is an immediate bit there
          3'b000:  code = (opcode5_i & func7_5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b100:  code = ALU_XOR;
          3'b101:  code = ALU_SRL;
          3'b110:  code = ALU_OR;
          3'b111:  code = ALU_AND;
          default: code = ALU_ADD;
        endcase
      end
      default:   code = ALU_ADD;
    endcase
  end

  assign alu_control_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM with memory-ready watchdog.
// Optional macro MC_CTRL_BRANCH_EXT_EN adds blt/bge/bltu/bgeu branch decode.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int WAIT_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func3,
  input  logic                  func7_5,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic                  fault
);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t                 ctrl_c, ctrl_g;
  logic                  taken, wait_st, timeout;

  always_comb begin
    taken = 1'b0;
    case (func3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
`ifdef MC_CTRL_BRANCH_EXT_EN
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
`endif
      default: taken = 1'b0;
    endcase
  end

`ifndef MC_CTRL_BRANCH_EXT_EN
  logic unused_flags;
  assign unused_flags = lt ^ ltu;
`endif

  // Watchdog only runs in the states that wait on memory
  assign wait_st = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign timeout = wait_st & ~mem_ready & (&cnt_q);
  assign cnt_d   = (wait_st && !mem_ready) ? cnt_q + 1'b1 : '0;

  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      FETCH: begin
        ctrl_c.mem_req    = 1'b1;
        ctrl_c.alu_src_b  = SRCB_FOUR;
        ctrl_c.result_src = RES_ALU;
        if (mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = DECODE;
        end
      end
      DECODE: begin
        ctrl_c.alu_src_a = SRCA_OLDPC;
        ctrl_c.alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_LUI:            state_d = LUI;
          default: begin
            ctrl_c.illegal = 1'b1;
            state_d        = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_IMM;
        state_d          = opcode[5] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.adr_src = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        ctrl_c.result_src = RES_RDATA;
        ctrl_c.reg_write  = 1'b1;
        state_d           = FETCH;
      end
      MEMWR: begin
        ctrl_c.mem_req   = 1'b1;
        ctrl_c.mem_write = 1'b1;
        ctrl_c.adr_src   = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXEC_R: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_RS2;
        ctrl_c.alu_op    = AOP_FUNC;
        state_d          = ALUWB;
      end
      EXEC_I: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = AOP_FUNC;
        state_d          = ALUWB;
      end
      ALUWB: begin
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.reg_write  = 1'b1;
        state_d           = FETCH;
      end
      BRANCH: begin
        ctrl_c.alu_src_a  = SRCA_RS1;
        ctrl_c.alu_src_b  = SRCB_RS2;
        ctrl_c.alu_op     = AOP_SUB;
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.pc_write   = taken;
        state_d           = FETCH;
      end
      JAL: begin
        // PC takes the target computed in DECODE; ALU forms the link value
        ctrl_c.alu_src_a  = SRCA_OLDPC;
        ctrl_c.alu_src_b  = SRCB_FOUR;
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.pc_write   = 1'b1;
        state_d           = ALUWB;
      end
      LUI: begin
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = AOP_PASSB;
        state_d          = ALUWB;
      end
      FAULT: ctrl_c.fault = 1'b1;
      default: state_d = FETCH;
    endcase
    if (timeout) state_d = FAULT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are held quiet for the whole time rst is high
  assign ctrl_g = rst ? '0 : ctrl_c;

  mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .op_i         (ctrl_g.alu_op),
    .func3_i      (func3),
    .opcode5_i    (opcode[5]),
    .func7_5_i    (func7_5),
    .alu_control_o(alu_control)
  );

  assign mem_req    = ctrl_g.mem_req;
  assign mem_write  = ctrl_g.mem_write;
  assign adr_src    = ctrl_g.adr_src;
  assign ir_write   = ctrl_g.ir_write;
  assign pc_write   = ctrl_g.pc_write;
  assign reg_write  = ctrl_g.reg_write;
  assign alu_src_a  = ctrl_g.alu_src_a;
  assign alu_src_b  = ctrl_g.alu_src_b;
  assign result_src = ctrl_g.result_src;
  assign illegal    = ctrl_g.illegal;
  assign fault      = ctrl_g.fault;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit (WAIT_CNT_W=2 so the watchdog trips quickly).
module tb_mc_control_unit;
  import mc_ctrl_pkg::*;

`ifdef MC_CTRL_BRANCH_EXT_EN
  localparam logic EXT = 1'b1;
`else
  localparam logic EXT = 1'b0;
`endif

  // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,a,b,res,alu,illegal,fault}
  localparam logic [16:0] V_FETCH_RDY  = 17'b1_0_0_1_1_0_00_10_10_000_0_0;
  localparam logic [16:0] V_FETCH_WAIT = 17'b1_0_0_0_0_0_00_10_10_000_0_0;
  localparam logic [16:0] V_DECODE     = 17'b0_0_0_0_0_0_01_01_00_000_0_0;
  localparam logic [16:0] V_MEMADR     = 17'b0_0_0_0_0_0_10_01_00_000_0_0;
  localparam logic [16:0] V_MEMRD      = 17'b1_0_1_0_0_0_00_00_00_000_0_0;
  localparam logic [16:0] V_MEMWB      = 17'b0_0_0_0_0_1_00_00_01_000_0_0;
  localparam logic [16:0] V_MEMWR      = 17'b1_1_1_0_0_0_00_00_00_000_0_0;
  localparam logic [16:0] V_EXEC_R_ADD = 17'b0_0_0_0_0_0_10_00_00_000_0_0;
  localparam logic [16:0] V_ALUWB      = 17'b0_0_0_0_0_1_00_00_00_000_0_0;
  localparam logic [16:0] V_JAL        = 17'b0_0_0_0_1_0_01_10_00_000_0_0;
  localparam logic [16:0] V_LUI        = 17'b0_0_0_0_0_0_00_01_00_100_0_0;
  localparam logic [16:0] V_ILLEGAL    = 17'b0_0_0_0_0_0_01_01_00_000_1_0;
  localparam logic [16:0] V_FAULT      = 17'b0_0_0_0_0_0_00_00_00_000_0_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_5, zero, lt, ltu, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  logic       illegal, fault;
  logic [16:0] outs;

  int ncmp = 0;
  int nerr = 0;

  mc_control_unit #(.ALU_CTRL_W(3), .WAIT_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7_5(func7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .illegal(illegal), .fault(fault)
  );

  assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, result_src, alu_control, illegal, fault};

  always #5 clk = ~clk;

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; func3 = f3; func7_5 = f7;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    set_instr(7'b0, 3'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    ncmp++;
    if (outs !== 17'b0 || dut.state_q !== FETCH || dut.cnt_q !== 2'b00) begin
      $display("FAIL reset_hold: outs=%b st=%0d cnt=%0d, want outs=0 st=%0d cnt=0",
               outs, dut.state_q, dut.cnt_q, FETCH);
      nerr++;
    end
    rst = 1'b0; #1;
    ncmp++;
    if (outs !== V_FETCH_WAIT) begin
      $display("FAIL reset_release: outs=%b want %b", outs, V_FETCH_WAIT);
      nerr++;
    end
  endtask

  task automatic test_add();
    logic [31:0] instr;
    logic [16:0] ex [4];
    state_t      st [4];
    instr = 32'h002081B3;
    ex = '{V_FETCH_RDY, V_DECODE, V_EXEC_R_ADD, V_ALUWB};
    st = '{FETCH, DECODE, EXEC_R, ALUWB};
    set_instr(instr[6:0], instr[14:12], instr[30]);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      ncmp++;
      if (outs !== ex[i] || dut.state_q !== st[i]) begin
        $display("FAIL add_c%0d: outs=%b st=%0d, want outs=%b st=%0d", i + 1, outs, dut.state_q, ex[i], st[i]);
        nerr++;
      end
      tick();
    end
    ncmp++;
    if (dut.state_q !== FETCH) begin
      $display("FAIL add_done: st=%0d want %0d", dut.state_q, FETCH);
      nerr++;
    end
  endtask

  task automatic test_alu_decode();
    logic [6:0] ops [9];
    logic [2:0] f3s [9];
    logic       f7s [9];
    logic [2:0] exp [9];
    state_t     est;
    ops = '{OP_R, OP_I, OP_R, OP_I, OP_R, OP_I, OP_R, OP_R, OP_I};
    f3s = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
    f7s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp = '{3'b001, 3'b000, 3'b101, 3'b110, 3'b111, 3'b011, 3'b010, 3'b000, 3'b000};
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_instr(ops[i], f3s[i], f7s[i]);
      est = (ops[i] == OP_R) ? EXEC_R : EXEC_I;
      tick(); tick();
      #1;
      ncmp++;
      if (alu_control !== exp[i] || dut.state_q !== est || reg_write !== 1'b0) begin
        $display("FAIL alu_dec_%0d: alu=%b st=%0d rw=%b, want alu=%b st=%0d rw=0",
                 i, alu_control, dut.state_q, reg_write, exp[i], est);
        nerr++;
      end
      tick(); tick();
    end
  endtask

  task automatic test_lw();
    logic        rdy [7];
    logic [16:0] ex  [7];
    state_t      st  [7];
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ex  = '{V_FETCH_RDY, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
    st  = '{FETCH, DECODE, MEMADR, MEMRD, MEMRD, MEMRD, MEMWB};
    set_instr(OP_LOAD, 3'b010, 1'b0);
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      ncmp++;
      if (outs !== ex[i] || dut.state_q !== st[i]) begin
        $display("FAIL lw_c%0d: outs=%b st=%0d, want outs=%b st=%0d", i + 1, outs, dut.state_q, ex[i], st[i]);
        nerr++;
      end
      tick();
    end
    ncmp++;
    if (dut.state_q !== FETCH) begin
      $display("FAIL lw_done: st=%0d want %0d", dut.state_q, FETCH);
      nerr++;
    end
  endtask

  task automatic test_sw();
    logic [16:0] ex [4];
    state_t      st [4];
    ex = '{V_FETCH_RDY, V_DECODE, V_MEMADR, V_MEMWR};
    st = '{FETCH, DECODE, MEMADR, MEMWR};
    set_instr(OP_STORE, 3'b010, 1'b0);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      ncmp++;
      if (outs !== ex[i] || dut.state_q !== st[i]) begin
        $display("FAIL sw_c%0d: outs=%b st=%0d, want outs=%b st=%0d", i + 1, outs, dut.state_q, ex[i], st[i]);
        nerr++;
      end
      tick();
    end
    ncmp++;
    if (dut.state_q !== FETCH) begin
      $display("FAIL sw_done: st=%0d want %0d", dut.state_q, FETCH);
      nerr++;
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3s [12];
    logic        zs  [12];
    logic        lts [12];
    logic        lus [12];
    logic        pws [12];
    logic [16:0] exv;
    f3s = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b011,
            3'b100, 3'b101, 3'b101, 3'b110, 3'b111, 3'b111};
    zs  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    lts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    lus = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    pws = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, EXT, 1'b0, EXT, EXT, 1'b0, EXT};
    mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_instr(OP_BRANCH, f3s[i], 1'b0);
      zero = zs[i]; lt = lts[i]; ltu = lus[i];
      exv = {4'b0000, pws[i], 1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 2'b00};
      tick(); tick();
      #1;
      ncmp++;
      if (outs !== exv || dut.state_q !== BRANCH) begin
        $display("FAIL branch_%0d f3=%b: outs=%b st=%0d, want outs=%b st=%0d",
                 i, f3s[i], outs, dut.state_q, exv, BRANCH);
        nerr++;
      end
      tick();
      ncmp++;
      if (dut.state_q !== FETCH) begin
        $display("FAIL branch_%0d_next: st=%0d want %0d", i, dut.state_q, FETCH);
        nerr++;
      end
    end
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
  endtask

  task automatic test_jal_lui();
    logic [16:0] ex [2][4];
    state_t      st [2][4];
    logic [6:0]  ops [2];
    ops = '{OP_JAL, OP_LUI};
    ex  = '{'{V_FETCH_RDY, V_DECODE, V_JAL, V_ALUWB}, '{V_FETCH_RDY, V_DECODE, V_LUI, V_ALUWB}};
    st  = '{'{FETCH, DECODE, JAL, ALUWB}, '{FETCH, DECODE, LUI, ALUWB}};
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_instr(ops[k], 3'b000, 1'b0);
      for (int i = 0; i < 4; i++) begin
        #1;
        ncmp++;
        if (outs !== ex[k][i] || dut.state_q !== st[k][i]) begin
          $display("FAIL %s_c%0d: outs=%b st=%0d, want outs=%b st=%0d", (k == 0) ? "jal" : "lui",
                   i + 1, outs, dut.state_q, ex[k][i], st[k][i]);
          nerr++;
        end
        tick();
      end
    end
  endtask

  task automatic test_illegal();
    logic        rdy [3];
    logic [16:0] ex  [3];
    state_t      st  [3];
    rdy = '{1'b1, 1'b1, 1'b0};
    ex  = '{V_FETCH_RDY, V_ILLEGAL, V_FETCH_WAIT};
    st  = '{FETCH, DECODE, FETCH};
    set_instr(7'b1111111, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = rdy[i];
      #1;
      ncmp++;
      if (outs !== ex[i] || dut.state_q !== st[i]) begin
        $display("FAIL illegal_c%0d: outs=%b st=%0d, want outs=%b st=%0d", i + 1, outs, dut.state_q, ex[i], st[i]);
        nerr++;
      end
      tick();
    end
  endtask

  task automatic test_rst_mid_memwr();
    set_instr(OP_STORE, 3'b010, 1'b0);
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0; #1;
    ncmp++;
    if (mem_write !== 1'b1 || mem_req !== 1'b1 || dut.state_q !== MEMWR) begin
      $display("FAIL rst_memwr_pre: mw=%b mreq=%b st=%0d, want 1 1 %0d", mem_write, mem_req, dut.state_q, MEMWR);
      nerr++;
    end
    #2 rst = 1'b1;
    #1;
    ncmp++;
    if (outs !== 17'b0 || dut.state_q !== FETCH) begin
      $display("FAIL rst_memwr_async: outs=%b st=%0d, want outs=0 st=%0d", outs, dut.state_q, FETCH);
      nerr++;
    end
    tick();
    rst = 1'b0; #1;
    ncmp++;
    if (outs !== V_FETCH_WAIT || dut.state_q !== FETCH) begin
      $display("FAIL rst_memwr_release: outs=%b st=%0d, want outs=%b st=%0d", outs, dut.state_q, V_FETCH_WAIT, FETCH);
      nerr++;
    end
  endtask

  task automatic test_ready_wins();
    set_instr(7'b1111111, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      ncmp++;
      if (outs !== ((i == 3) ? V_FETCH_RDY : V_FETCH_WAIT) || dut.state_q !== FETCH) begin
        $display("FAIL ready_wins_c%0d: outs=%b st=%0d", i + 1, outs, dut.state_q);
        nerr++;
      end
      tick();
    end
    ncmp++;
    if (dut.state_q !== DECODE) begin
      $display("FAIL ready_wins_next: st=%0d want %0d", dut.state_q, DECODE);
      nerr++;
    end
    tick();
  endtask

  task automatic test_watchdog();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      ncmp++;
      if (outs !== V_FETCH_WAIT || dut.state_q !== FETCH) begin
        $display("FAIL wdog_wait_c%0d: outs=%b st=%0d, want outs=%b st=%0d", i + 1, outs, dut.state_q, V_FETCH_WAIT, FETCH);
        nerr++;
      end
      tick();
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      ncmp++;
      if (outs !== V_FAULT || dut.state_q !== FAULT) begin
        $display("FAIL wdog_fault_c%0d: outs=%b st=%0d, want outs=%b st=%0d", i, outs, dut.state_q, V_FAULT, FAULT);
        nerr++;
      end
      tick();
    end
    rst = 1'b1; #1;
    ncmp++;
    if (fault !== 1'b0 || outs !== 17'b0) begin
      $display("FAIL wdog_rst: fault=%b outs=%b, want 0", fault, outs);
      nerr++;
    end
    tick();
    rst = 1'b0; mem_ready = 1'b0; #1;
    ncmp++;
    if (outs !== V_FETCH_WAIT || dut.state_q !== FETCH) begin
      $display("FAIL wdog_cleared: outs=%b st=%0d, want outs=%b st=%0d", outs, dut.state_q, V_FETCH_WAIT, FETCH);
      nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_decode();
    test_lw();
    test_sw();
    test_branch();
    test_jal_lui();
    test_illegal();
    test_rst_mid_memwr();
    test_ready_wins();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
